// File: rtl/hdmi_init_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_init_pkg
// Purpose  : Shared types for the HDMI transmitter I2C init sequencer:
//            sequencer state enum, delay-marker register code and the
//            register-table entry struct.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hdmi_init_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PWR_WAIT = 4'd1,
    ST_FETCH    = 4'd2,
    ST_ISSUE    = 4'd3,
    ST_WAIT_HI  = 4'd4,
    ST_WAIT_LO  = 4'd5,
    ST_DELAY    = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERROR    = 4'd8
  } state_t;

  // A table entry whose register field holds this code is a pause of
  // data*256 clock cycles instead of an I2C write.
  localparam logic [7:0] DELAY_MARKER = 8'hFE;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } entry_t;

  function automatic entry_t mk_entry(input logic [7:0] r, input logic [7:0] d);
    entry_t e;
    e.reg_addr = r;
    e.data     = d;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_init_rom.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_init_rom
// Purpose  : Register-initialisation table of the HDMI transmitter. The only
//            place the table contents live. Registered read, 1-cycle latency.
// Ports    : clk     - rising-edge clock
//            rst     - synchronous active-high reset (clears the output)
//            idx_i   - table index (0..63)
//            entry_o - {reg_addr, data} of idx_i, one cycle later
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_init_rom
  import hdmi_init_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] idx_i,
  output entry_t     entry_o
);

  entry_t entry_d;
  entry_t entry_q;

  always_comb begin
    entry_d = mk_entry(8'h41, 8'h10);
    case (idx_i)
      6'd0:  entry_d = mk_entry(8'h41, 8'h10);  // power up the transmitter
      6'd1:  entry_d = mk_entry(8'h98, 8'h03);
      6'd2:  entry_d = mk_entry(8'h9A, 8'hE0);
      6'd3:  entry_d = mk_entry(DELAY_MARKER, 8'h02);  // 512-cycle settle
      6'd4:  entry_d = mk_entry(8'h9C, 8'h30);
      6'd5:  entry_d = mk_entry(8'h9D, 8'h61);
      6'd6:  entry_d = mk_entry(8'hA2, 8'hA4);
      6'd7:  entry_d = mk_entry(8'hA3, 8'hA4);
      6'd8:  entry_d = mk_entry(8'hE0, 8'hD0);
      6'd9:  entry_d = mk_entry(8'hF9, 8'h00);
      6'd10: entry_d = mk_entry(8'h15, 8'h00);
      6'd11: entry_d = mk_entry(8'h16, 8'h30);
      6'd12: entry_d = mk_entry(8'h17, 8'h02);
      6'd13: entry_d = mk_entry(8'h18, 8'h46);
      6'd14: entry_d = mk_entry(8'hAF, 8'h06);
      6'd15: entry_d = mk_entry(8'hD6, 8'hC0);
      // Unpopulated slots repeat the idempotent power-up write.
      default: entry_d = mk_entry(8'h41, 8'h10);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) entry_q <= '0;
    else     entry_q <= entry_d;
  end

  assign entry_o = entry_q;

endmodule
`default_nettype wire

// File: rtl/hdmi_i2c_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_i2c_init_seq
// Purpose  : Walks the HDMI transmitter register table after a power-up wait
//            and issues one I2C write per entry to an external I2C master.
//            Delay-marker entries pause instead of writing.
// Ports    : clk, rst (sync, active-high), go (one-cycle run request)
//            i2c_cmd_address/i2c_reg/i2c_data/i2c_start -> I2C master
//            i2c_busy/i2c_nack <- I2C master
//            done, error (held until next go/rst), entry_idx (current entry)
// Config   : HDMI_INIT_RETRY_EN - when defined, a NACKed entry is reissued up
//            to MAX_RETRY times before aborting; otherwise any NACK aborts.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_i2c_init_seq
  import hdmi_init_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'h39,
  parameter int         NUM_ENTRIES    = 16,
  parameter int         POWERUP_CYCLES = 200000,
  parameter int         BUSY_TIMEOUT   = 1024,
  parameter int         MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  output logic [6:0] i2c_cmd_address,
  output logic [7:0] i2c_reg,
  output logic [7:0] i2c_data,
  output logic       i2c_start,
  input  logic       i2c_busy,
  input  logic       i2c_nack,
  output logic       done,
  output logic       error,
  output logic [5:0] entry_idx
);

  localparam logic [5:0]  LAST_IDX     = 6'(NUM_ENTRIES - 1);
  localparam logic [31:0] PWR_LOAD     = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LOAD = 32'(BUSY_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  data_q, data_d;
  logic        start_q, start_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        w_advance;
  entry_t      w_rom;

`ifdef HDMI_INIT_RETRY_EN
  logic [7:0]  retry_q, retry_d;
`else
  logic [7:0]  w_unused_max_retry;
  assign w_unused_max_retry = 8'(MAX_RETRY);
`endif

  // The ROM is addressed with the next index so the entry is already
  // registered at its output during the FETCH cycle that follows.
  hdmi_init_rom u_rom (
    .clk     (clk),
    .rst     (rst),
    .idx_i   (idx_d),
    .entry_o (w_rom)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    reg_d     = reg_q;
    data_d    = data_q;
    start_d   = 1'b0;
    w_advance = 1'b0;
`ifdef HDMI_INIT_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (go) begin
          state_d = ST_PWR_WAIT;
          idx_d   = '0;
          cnt_d   = PWR_LOAD;
        end
      end
      ST_PWR_WAIT: begin
        if (cnt_q == '0) state_d = ST_FETCH;
        else             cnt_d   = cnt_q - 32'd1;
      end
      ST_FETCH: begin
        reg_d  = w_rom.reg_addr;
        data_d = w_rom.data;
`ifdef HDMI_INIT_RETRY_EN
        retry_d = '0;
`endif
        if (w_rom.reg_addr == DELAY_MARKER) begin
          // A zero-length delay simply moves on to the next entry.
          if (w_rom.data == 8'h00) begin
            w_advance = 1'b1;
          end else begin
            state_d = ST_DELAY;
            cnt_d   = {16'h0000, w_rom.data, 8'h00} - 32'd1;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!i2c_busy) begin
          start_d = 1'b1;
          state_d = ST_WAIT_HI;
          cnt_d   = TIMEOUT_LOAD;
        end
      end
      ST_WAIT_HI: begin
        if (i2c_busy)          state_d = ST_WAIT_LO;
        else if (cnt_q == '0)  state_d = ST_ERROR;
        else                   cnt_d   = cnt_q - 32'd1;
      end
      ST_WAIT_LO: begin
        if (!i2c_busy) begin
          if (!i2c_nack) begin
            w_advance = 1'b1;
          end else begin
`ifdef HDMI_INIT_RETRY_EN
            if (retry_q == 8'(MAX_RETRY)) begin
              state_d = ST_ERROR;
            end else begin
              retry_d = retry_q + 8'd1;
              state_d = ST_ISSUE;
            end
`else
            state_d = ST_ERROR;
`endif
          end
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) w_advance = 1'b1;
        else             cnt_d     = cnt_q - 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = ST_DONE;
      end else begin
        idx_d   = idx_q + 6'd1;
        state_d = ST_FETCH;
      end
    end

    // Flags track the state being entered so they coincide with it.
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      start_q <= start_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

`ifdef HDMI_INIT_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst) retry_q <= '0;
    else     retry_q <= retry_d;
  end
`endif

  assign i2c_cmd_address = DEV_ADDR;
  assign i2c_reg         = reg_q;
  assign i2c_data        = data_q;
  assign i2c_start       = start_q;
  assign done            = done_q;
  assign error           = error_q;
  assign entry_idx       = idx_q;

endmodule
`default_nettype wire
